// File: rtl/sobel_edge_detector_pkg.sv
// Shared widths, pipeline latency and a helper for the Sobel edge detector.
package sobel_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned GRAD_W   = 11;                // signed gradient, +/-1020
  localparam int unsigned MAG2_W   = 21;                // Gx^2 + Gy^2
  localparam int unsigned PIPE_LAT = 4;
  localparam int unsigned ABS_W    = GRAD_W - 1;        // |G| <= 1020 fits 10 bits
  localparam int unsigned SQ_W     = 2 * ABS_W;         // single square
  localparam int unsigned TH2_W    = 2 * PIX_W;         // squared threshold

  // Magnitude of a gradient; the range never reaches -1024 so ABS_W bits suffice.
  function automatic logic [ABS_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    if (g[GRAD_W-1]) begin
      return ~g[ABS_W-1:0] + ABS_W'(1);
    end
    return g[ABS_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_edge_detector_if.sv
// Video stream interface: pre_* is the incoming luma stream, post_* the edge map.
// Carries post_img_grad only when SOBEL_GRAD_OUT_EN is defined.
interface sobel_edge_detector_if;
  import sobel_pkg::*;

  logic             pre_frame_vsync;
  logic             pre_frame_href;
  logic             pre_frame_clken;
  logic [PIX_W-1:0] pre_img_Y;
  logic             post_frame_vsync;
  logic             post_frame_href;
  logic             post_frame_clken;
  logic             post_img_Bit;
`ifdef SOBEL_GRAD_OUT_EN
  logic [7:0]       post_img_grad;
`endif

  // Source of the luma stream, sink of the edge map.
  modport master (
    output pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_Y,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
`ifdef SOBEL_GRAD_OUT_EN
    , input post_img_grad
`endif
  );

  // The edge detector itself.
  modport slave (
    input  pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_Y,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
`ifdef SOBEL_GRAD_OUT_EN
    , output post_img_grad
`endif
  );

endinterface

// File: rtl/sobel_edge_detector_matrix.sv
// vip_matrix_3x3: two line buffers, the 3x3 window and the col/row counters.
// Window and border flag appear one clock after the accepted pixel.
module vip_matrix_3x3
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_HDISP = 400,
  parameter int unsigned IMG_VDISP = 400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_vsync,
  input  logic             accept,
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] p11, p12, p13,
  output logic [PIX_W-1:0] p21, p22, p23,
  output logic [PIX_W-1:0] p31, p32, p33,
  output logic             border,
  output logic             valid
);

  localparam int unsigned COL_W = (IMG_HDISP > 2) ? $clog2(IMG_HDISP) : 2;
  localparam int unsigned ROW_W = (IMG_VDISP > 2) ? $clog2(IMG_VDISP) : 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_HDISP - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_VDISP - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] line1 [IMG_HDISP];
  logic [PIX_W-1:0] line2 [IMG_HDISP];
  logic [PIX_W-1:0] tap1;
  logic [PIX_W-1:0] tap2;

  // Same column one line ago (tap1) and two lines ago (tap2).
  always_comb begin
    tap1 = line1[col];
    tap2 = line2[col];
  end

  // Line buffers cascade on accept; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      line1[col] <= pix;
      line2[col] <= tap1;
    end
  end

  // Raster position of the newest pixel; held at origin outside the frame.
  always_ff @(posedge clk) begin
    if (!rst_n || !frame_vsync) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Column-shift window: row 1 oldest line, row 3 newest, column 3 newest pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
    end else if (accept) begin
      p11 <= p12;  p12 <= p13;  p13 <= tap2;
      p21 <= p22;  p22 <= p23;  p23 <= tap1;
      p31 <= p32;  p32 <= p33;  p33 <= pix;
    end
  end

  // Border qualifier travels with the window it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      border <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= accept;
      if (accept) begin
        border <= (col < COL_W'(2)) || (row < ROW_W'(2));
      end
    end
  end

endmodule

// File: rtl/sobel_edge_detector.sv
// Streaming 3x3 Sobel edge detector, fixed 4-clock latency with sync delayed alongside.
// Optional SOBEL_GRAD_OUT_EN adds post_img_grad = min(|Gx|+|Gy|, 255).
module sobel_edge_detector
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_HDISP = 400,
  parameter int unsigned IMG_VDISP = 400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] Sobel_Threshold,
  sobel_edge_detector_if.slave vid
);

  logic                     accept;
  logic [PIX_W-1:0]         p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic                     border_s1, valid_s1;
  logic [GRAD_W-2:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [GRAD_W-1:0] gx, gy, gx_s2, gy_s2;
  logic                     border_s2, valid_s2;
  logic [ABS_W-1:0]         ax, ay;
  logic [SQ_W-1:0]          sq_x, sq_y;
  logic [MAG2_W-1:0]        mag2, mag2_s3;
  logic [TH2_W-1:0]         th2, th2_s3;
  logic                     border_s3, valid_s3;
  logic                     edge_bit;
  logic [PIPE_LAT-1:0]      vsync_dly, href_dly, clken_dly;

  always_comb accept = vid.pre_frame_href & vid.pre_frame_clken;

  // Stage 1: window update.
  vip_matrix_3x3 #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_matrix (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_vsync (vid.pre_frame_vsync),
    .accept      (accept),
    .pix         (vid.pre_img_Y),
    .p11 (p11), .p12 (p12), .p13 (p13),
    .p21 (p21), .p22 (p22), .p23 (p23),
    .p31 (p31), .p32 (p32), .p33 (p33),
    .border      (border_s1),
    .valid       (valid_s1)
  );

  // Sync signals ride a plain delay line matching the data pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_dly <= '0;
      href_dly  <= '0;
      clken_dly <= '0;
    end else begin
      vsync_dly <= {vsync_dly[PIPE_LAT-2:0], vid.pre_frame_vsync};
      href_dly  <= {href_dly[PIPE_LAT-2:0],  vid.pre_frame_href};
      clken_dly <= {clken_dly[PIPE_LAT-2:0], vid.pre_frame_clken};
    end
  end

  // Gradient kernels as unsigned positive/negative halves, then one signed subtract.
  always_comb begin
    gx_pos = {2'b00, p13} + {1'b0, p23, 1'b0} + {2'b00, p33};
    gx_neg = {2'b00, p11} + {1'b0, p21, 1'b0} + {2'b00, p31};
    gy_pos = {2'b00, p11} + {1'b0, p12, 1'b0} + {2'b00, p13};
    gy_neg = {2'b00, p31} + {1'b0, p32, 1'b0} + {2'b00, p33};
    gx     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
  end

  // Stage 2: register Gx, Gy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gx_s2     <= '0;
      gy_s2     <= '0;
      border_s2 <= 1'b0;
      valid_s2  <= 1'b0;
    end else begin
      gx_s2     <= gx;
      gy_s2     <= gy;
      border_s2 <= border_s1;
      valid_s2  <= valid_s1;
    end
  end

  // Squares of magnitudes; comparing squares avoids a square root.
  always_comb begin
    ax   = abs_grad(gx_s2);
    ay   = abs_grad(gy_s2);
    sq_x = {{ABS_W{1'b0}}, ax} * {{ABS_W{1'b0}}, ax};
    sq_y = {{ABS_W{1'b0}}, ay} * {{ABS_W{1'b0}}, ay};
    mag2 = {1'b0, sq_x} + {1'b0, sq_y};
    th2  = {{PIX_W{1'b0}}, Sobel_Threshold} * {{PIX_W{1'b0}}, Sobel_Threshold};
  end

  // Stage 3: register squared magnitude and squared threshold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag2_s3   <= '0;
      th2_s3    <= '0;
      border_s3 <= 1'b0;
      valid_s3  <= 1'b0;
    end else begin
      mag2_s3   <= mag2;
      th2_s3    <= th2;
      border_s3 <= border_s2;
      valid_s3  <= valid_s2;
    end
  end

  // Stage 4: compare; forced low at borders and on non-pixel cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_bit <= 1'b0;
    end else begin
      edge_bit <= valid_s3 & ~border_s3 &
                  (mag2_s3 >= {{(MAG2_W - TH2_W){1'b0}}, th2_s3});
    end
  end

`ifdef SOBEL_GRAD_OUT_EN
  logic [GRAD_W-1:0] abs_sum;
  logic [7:0]        grad_sat, grad_s3, grad_s4;

  always_comb begin
    abs_sum  = {1'b0, ax} + {1'b0, ay};
    grad_sat = (abs_sum > GRAD_W'(255)) ? 8'hFF : abs_sum[7:0];
  end

  // L1 gradient follows the same stage 3/4 timing as the edge bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grad_s3 <= '0;
      grad_s4 <= '0;
    end else begin
      grad_s3 <= grad_sat;
      grad_s4 <= (valid_s3 & ~border_s3) ? grad_s3 : 8'h00;
    end
  end

  always_comb vid.post_img_grad = grad_s4;
`endif

  // Drive the interface outputs from the final registers.
  always_comb begin
    vid.post_frame_vsync = vsync_dly[PIPE_LAT-1];
    vid.post_frame_href  = href_dly[PIPE_LAT-1];
    vid.post_frame_clken = clken_dly[PIPE_LAT-1];
    vid.post_img_Bit     = edge_bit;
  end

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Directed bench for sobel_edge_detector on a reduced 16x12 frame.
module tb_sobel_edge_detector;
  import sobel_pkg::*;

  localparam int H = 16;
  localparam int V = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] th = 8'd0;

  sobel_edge_detector_if vid ();

  sobel_edge_detector #(
    .IMG_HDISP (H),
    .IMG_VDISP (V)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Sobel_Threshold (th),
    .vid             (vid)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] img [V][H];
  bit         out_q [$];
  bit         ref_q [$];
  bit         cap_en = 1'b0;
  bit         sync_en = 1'b0;
  int         sync_err = 0;
  int         idle_err = 0;
  logic [2:0] hist [4] = '{3'b000, 3'b000, 3'b000, 3'b000};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Output monitor: sync delay, idle-low rule and capture of valid output bits.
  always @(negedge clk) begin
    if (sync_en && ({vid.post_frame_vsync, vid.post_frame_href, vid.post_frame_clken}
                    !== hist[3])) sync_err++;
    if (cap_en) begin
      if (vid.post_frame_href && vid.post_frame_clken) out_q.push_back(vid.post_img_Bit);
      else if (vid.post_img_Bit !== 1'b0) idle_err++;
    end
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {vid.pre_frame_vsync, vid.pre_frame_href, vid.pre_frame_clken};
  end

  function automatic int model_bit(input int r, input int c, input int t);
    int p [3][3];
    int gx, gy;
    if (c < 2 || r < 2) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) p[i][j] = int'(img[r-2+i][c-2+j]);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[0][0] + 2*p[0][1] + p[0][2]) - (p[2][0] + 2*p[2][1] + p[2][2]);
    return (gx*gx + gy*gy >= t*t) ? 1 : 0;
  endfunction

  function automatic int bit_at(input int r, input int c);
    if (r*H + c >= out_q.size()) return -1;
    return int'(out_q[r*H + c]);
  endfunction

  function automatic int ones();
    int n = 0;
    foreach (out_q[i]) n += int'(out_q[i]);
    return n;
  endfunction

  task automatic drive(input logic href, input logic clken, input logic [7:0] y);
    vid.pre_frame_href  = href;
    vid.pre_frame_clken = clken;
    vid.pre_img_Y       = y;
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_vsync", int'(vid.post_frame_vsync), 0);
      check("rst_mid_href",  int'(vid.post_frame_href), 0);
      check("rst_mid_clken", int'(vid.post_frame_clken), 0);
      check("rst_mid_bit",   int'(vid.post_img_Bit), 0);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input bit gaps, input int rst_row);
    out_q.delete();
    sync_err = 0;
    idle_err = 0;
    cap_en   = (rst_row < 0);
    sync_en  = (rst_row < 0);
    vid.pre_frame_vsync = 1'b1;
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    for (int r = 0; r < V; r++) begin
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      for (int c = 0; c < H; c++) begin
        if (r == rst_row && c == 0) mid_reset();
        if (gaps && (c == 5 || c == 11)) repeat (5) drive(1'b1, 1'b0, 8'hA5);
        drive(1'b1, 1'b1, img[r][c]);
      end
      drive(1'b0, 1'b0, 8'h00);
    end
    repeat (8) drive(1'b0, 1'b0, 8'h00);
    vid.pre_frame_vsync = 1'b0;
    repeat (6) drive(1'b0, 1'b0, 8'h00);
    cap_en = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    int mism = 0;
    check({tag, "_count"}, out_q.size(), H*V);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        if (bit_at(r, c) != model_bit(r, c, int'(th))) mism++;
    check({tag, "_model"}, mism, 0);
    check({tag, "_sync"}, sync_err, 0);
    check({tag, "_idle"}, idle_err, 0);
  endtask

  task automatic fill_noise();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) img[r][c] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int mism;
    vid.pre_frame_vsync = 1'b0;
    vid.pre_frame_href  = 1'b0;
    vid.pre_frame_clken = 1'b0;
    vid.pre_img_Y       = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vsync", int'(vid.post_frame_vsync), 0);
    check("rst_href",  int'(vid.post_frame_href), 0);
    check("rst_clken", int'(vid.post_frame_clken), 0);
    check("rst_bit",   int'(vid.post_img_Bit), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Flat field: no edges anywhere.
    th = 8'd128;
    foreach (img[r, c]) img[r][c] = 8'h80;
    run_frame(1'b0, -1);
    compare_model("flat");
    check("flat_ones", ones(), 0);

    // Vertical step 0 -> 255 at column 8: edges at newest columns 8 and 9.
    foreach (img[r, c]) img[r][c] = (c < 8) ? 8'd0 : 8'd255;
    run_frame(1'b0, -1);
    compare_model("vstep");
    check("vstep_r5c7",  bit_at(5, 7), 0);
    check("vstep_r5c8",  bit_at(5, 8), 1);
    check("vstep_r5c9",  bit_at(5, 9), 1);
    check("vstep_r5c10", bit_at(5, 10), 0);
    check("vstep_r1c8",  bit_at(1, 8), 0);
    check("vstep_r11c9", bit_at(11, 9), 1);
    check("vstep_ones",  ones(), 2 * (V - 2));

    // Horizontal step of 32 at row 6: |Gy| = 128, exactly on the Th = 128 boundary.
    foreach (img[r, c]) img[r][c] = (r < 6) ? 8'd64 : 8'd96;
    run_frame(1'b0, -1);
    compare_model("hstep128");
    check("hstep_r5c5", bit_at(5, 5), 0);
    check("hstep_r6c5", bit_at(6, 5), 1);
    check("hstep_r7c5", bit_at(7, 5), 1);
    check("hstep_r8c5", bit_at(8, 5), 0);
    check("hstep_r6c1", bit_at(6, 1), 0);
    check("hstep_ones", ones(), 2 * (H - 2));
    th = 8'd129;
    run_frame(1'b0, -1);
    compare_model("hstep129");
    check("hstep129_ones", ones(), 0);

    // Noise with Th = 0: every interior pixel is an edge, every border pixel is not.
    th = 8'd0;
    fill_noise();
    run_frame(1'b0, -1);
    compare_model("border");
    check("border_r0c5",  bit_at(0, 5), 0);
    check("border_r5c1",  bit_at(5, 1), 0);
    check("border_r2c2",  bit_at(2, 2), 1);
    check("border_r11c15", bit_at(11, 15), 1);
    check("border_ones",  ones(), (H - 2) * (V - 2));

    // Blanking gaps must not change the edge map.
    th = 8'd100;
    run_frame(1'b0, -1);
    compare_model("nogap");
    ref_q = out_q;
    run_frame(1'b1, -1);
    compare_model("gap");
    mism = 0;
    if (out_q.size() == ref_q.size()) begin
      foreach (out_q[i]) if (out_q[i] != ref_q[i]) mism++;
    end else begin
      mism = -1;
    end
    check("gap_vs_nogap", mism, 0);

    // Reset mid-frame, then a clean frame.
    run_frame(1'b0, 6);
    fill_noise();
    run_frame(1'b0, -1);
    compare_model("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
